// File: rtl/core_scheduler_if.sv
// ============================================================================
// Module : core_scheduler_if
// Brief  : Host/core handshake bundle for the core run-control scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface core_scheduler_if #(
  parameter int NUM_CORES = 4
);
  logic                   start;
  logic [NUM_CORES-1:0]   core_mask;
  logic                   abort;
  logic                   done_ack;
  logic [NUM_CORES-1:0]   end_process;
  logic [2*NUM_CORES-1:0] status;
  logic                   busy;
  logic                   done;
  logic [NUM_CORES-1:0]   done_cores;
  logic [31:0]            cycle_count;

  modport master (
    output start, core_mask, abort, done_ack, end_process,
    input  status, busy, done, done_cores, cycle_count
  );

  modport slave (
    input  start, core_mask, abort, done_ack, end_process,
    output status, busy, done, done_cores, cycle_count
  );
endinterface

`default_nettype wire

// File: rtl/core_scheduler.sv
// ============================================================================
// Module : core_scheduler
// Brief  : Starts a subset of cores together, tracks completion, raises done.
//          Optional RUN-cycle counter enabled by macro SCHED_CYCLE_COUNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module core_scheduler #(
  parameter int NUM_CORES = 4
) (
  input  wire logic        clock,
  input  wire logic        reset,
  core_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_CORES-1:0]   active_q, active_d;
  logic [NUM_CORES-1:0]   done_cores_q, done_cores_d;
  logic [2*NUM_CORES-1:0] status_q, status_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_CORES-1:0]   new_done;

  // Finished cores park (10) ahead of running (01); unselected cores hold (00).
  function automatic logic [2*NUM_CORES-1:0] drive_status(
    input logic [NUM_CORES-1:0] act,
    input logic [NUM_CORES-1:0] fin
  );
    logic [2*NUM_CORES-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (fin[i])      s[2*i +: 2] = 2'b10;
      else if (act[i]) s[2*i +: 2] = 2'b01;
    end
    return s;
  endfunction

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    done_cores_d = done_cores_q;
    status_d     = status_q;
    busy_d       = busy_q;
    done_d       = done_q;
    new_done     = done_cores_q | (active_q & bus.end_process);

    case (state_q)
      S_IDLE: begin
        if (bus.start && (|bus.core_mask)) begin
          state_d      = S_ARM;
          active_d     = bus.core_mask;
          done_cores_d = '0;
          busy_d       = 1'b1;
        end
      end
      S_ARM: begin
        state_d  = S_RUN;
        status_d = drive_status(active_q, '0);
      end
      S_RUN: begin
        done_cores_d = new_done;
        status_d     = drive_status(active_q, new_done);
        if ((new_done & active_q) == active_q) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end
      end
      S_FINISH: begin
        if (bus.done_ack) begin
          state_d  = S_IDLE;
          status_d = '0;
          busy_d   = 1'b0;
          done_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.abort) begin
      state_d      = S_IDLE;
      status_d     = '0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      done_cores_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      active_q     <= '0;
      done_cores_q <= '0;
      status_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      done_cores_q <= done_cores_d;
      status_q     <= status_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.status     = status_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.done_cores = done_cores_q;

`ifdef SCHED_CYCLE_COUNT_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        start_accept;

  assign start_accept = (state_q == S_IDLE) && bus.start && (|bus.core_mask) && !bus.abort;

  always_comb begin
    cycle_count_d = cycle_count_q;
    if (start_accept)
      cycle_count_d = '0;
    else if ((state_q == S_RUN) && (cycle_count_q != 32'hFFFF_FFFF))
      cycle_count_d = cycle_count_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cycle_count_q <= '0;
    else       cycle_count_q <= cycle_count_d;
  end

  assign bus.cycle_count = cycle_count_q;
`else
  assign bus.cycle_count = 32'd0;
`endif

endmodule

`default_nettype wire
